// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg -- shared types and constants for the UART receiver slice.
//   rx_state_t          : receiver FSM states (ST_PARITY only exists when the
//                         UART_RX_PARITY_EN macro is defined)
//   DEFAULT_OVERSAMPLE  : default sample ticks per bit
//   DEFAULT_DATA_BITS   : default data bits per frame
//   mid_sample_idx()    : sample counter value at the middle of a bit
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_t;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;
    localparam int unsigned DEFAULT_DATA_BITS  = 8;

    // Counter value at which the start bit is re-checked; from then on every
    // full OVERSAMPLE period lands on the centre of the following bits.
    function automatic logic [3:0] mid_sample_idx(input int unsigned oversample);
        return 4'(oversample / 2 - 1);
    endfunction

endpackage

// File: rtl/rx_sample_timer.sv
// rx_sample_timer -- oversample counter for the UART receiver.
//   clk, rst : clock, asynchronous active-high reset
//   tick_en  : advance the counter by one (qualified sample tick)
//   clr      : synchronous clear, takes priority over tick_en
//   cnt      : current counter value, wraps from OVERSAMPLE-1 to 0
//   tc       : terminal count, high while cnt == OVERSAMPLE-1
module rx_sample_timer
    import uart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       clr,
    output logic [3:0] cnt,
    output logic       tc
);

    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick_en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- oversampling UART receiver with a one-entry output register.
//   clk, rst    : clock, asynchronous active-high reset
//   sample_tick : oversample strobe (one clk wide); all framing advances on it
//   rx_in       : synchronized serial line, idle high
//   rx_ready    : consumer accepts rx_data on a clk edge while rx_valid=1
//   rx_data     : received byte, LSB-aligned, upper unused bits 0
//   rx_valid    : rx_data holds an unconsumed byte
//   frame_err   : one-cycle pulse when the stop bit is sampled low
//   parity_err  : one-cycle pulse on even-parity mismatch (0 without parity)
//   overrun     : sticky, a completed frame was dropped; clears on next accept
//   busy        : receiver state is not IDLE
//   sample_cnt  : current oversample counter
//   bit_cnt     : current data bit index
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       rx_in,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy,
    output logic [3:0] sample_cnt,
    output logic [3:0] bit_cnt
);

    localparam logic [3:0] MID      = mid_sample_idx(OVERSAMPLE);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    rx_state_t state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic frame_err_q, frame_err_d;
    logic commit_q, commit_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic rx_valid_q, rx_valid_d;
    logic overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic parity_err_q, parity_err_d;
    logic par_bad_q, par_bad_d;
`endif

    logic cnt_clr;
    logic cnt_tc;

    rx_sample_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .tick_en (sample_tick && (state_q != ST_IDLE)),
        .clr     (cnt_clr),
        .cnt     (sample_cnt),
        .tc      (cnt_tc)
    );

    // Framing FSM: every transition is qualified by sample_tick.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        cnt_clr     = 1'b0;
        frame_err_d = 1'b0;
        commit_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
        par_bad_d    = par_bad_q;
`endif
        if (sample_tick) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_clr   = 1'b1;
                    bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                    if (!rx_in) begin
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (sample_cnt == MID) begin
                        cnt_clr   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = rx_in ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_tc) begin
                        shift_d   = {rx_in, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_tc) begin
                        par_bad_d    = rx_in ^ (^shift_q);
                        parity_err_d = rx_in ^ (^shift_q);
                        state_d      = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_tc) begin
                        frame_err_d = !rx_in;
`ifdef UART_RX_PARITY_EN
                        commit_d    = rx_in && !par_bad_q;
`else
                        commit_d    = rx_in;
`endif
                        bit_cnt_d   = '0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output register: a frame committed on the sampling edge is applied on
    // the following edge. shift_q cannot change in between because DATA is
    // at least one full tick away.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (commit_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = 8'(shift_q);
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            commit_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            commit_q    <= commit_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
            par_bad_q    <= par_bad_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl -- self-checking bench for uart_rx_ctrl (DATA_BITS=8,
// OVERSAMPLE=16). Frames are built as line levels, OVERSAMPLE ticks per bit;
// the expected bytes and error counts follow from the framing rules.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_ctrl;

    localparam int unsigned DB   = 8;
    localparam int unsigned OS   = 16;
    localparam int unsigned NONE = 32'hFFFF_FFFF;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun, busy;
    logic [3:0] sample_cnt, bit_cnt;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Written only by the monitor; the stimulus reads deltas.
    logic [7:0]  got[$];
    int unsigned fe_cnt = 0;
    int unsigned pe_cnt = 0;
    int unsigned vr_cnt = 0;
    logic        valid_prev = 1'b0;

    uart_rx_ctrl #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick),
        .rx_in      (rx_in),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy),
        .sample_cnt (sample_cnt),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            valid_prev = 1'b0;
        end else begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (parity_err) pe_cnt++;
            if (rx_valid && !valid_prev) vr_cnt++;
            valid_prev = rx_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One sample tick followed by 1..3 idle clocks; optionally raise rx_ready
    // for exactly the clock after the tick edge.
    task automatic tick(input logic v, input bit ready_pulse);
        int unsigned gap;
        gap = $urandom_range(1, 3);
        rx_in = v;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        if (ready_pulse) rx_ready = 1'b1;
        @(posedge clk); #1;
        if (ready_pulse) rx_ready = 1'b0;
        for (int unsigned i = 1; i < gap; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic ticks(input logic v, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick(v, 1'b0);
    endtask

    // Start bit, data LSB-first, optional even parity (flip_par inverts it),
    // stop bit, then 12 idle ticks. stop_after aborts at that tick index.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit flip_par,
                              input bit ready_at_commit, input int unsigned stop_after);
        logic        lv[12];
        int unsigned nb;
        lv[0] = 1'b0;
        nb = 1;
        for (int unsigned i = 0; i < DB; i++) begin
            lv[nb] = d[i];
            nb++;
        end
        if (PAR_EN) begin
            lv[nb] = (^d) ^ flip_par;
            nb++;
        end
        lv[nb] = stop_bit;
        nb++;
        for (int unsigned b = 0; b < nb; b++) begin
            for (int unsigned t = 0; t < OS; t++) begin
                if (b * OS + t == stop_after) return;
                tick(lv[b], ready_at_commit && (b == nb - 1) && (t == OS / 2));
            end
        end
        ticks(1'b1, 12);
    endtask

    function automatic bit frame_good(input logic stop_bit, input bit flip_par);
        return stop_bit && !(PAR_EN && flip_par);
    endfunction

    initial begin
        int unsigned base, fe0, pe0, vr0;
        logic [7:0]  exp_q[$];
        int unsigned fe_exp, pe_exp;

        // ---------------- reset ----------------
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {rx_data, rx_valid, frame_err, parity_err, overrun, busy,
                              sample_cnt, bit_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_busy", {31'd0, busy}, 32'd0);

        // ---------------- clean frame 0xA5 ----------------
        rx_ready = 1'b1;
        base = got.size(); fe0 = fe_cnt; vr0 = vr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, NONE);
        chk("a5_count", got.size() - base, 32'd1);
        chk("a5_data", {24'd0, got[base]}, 32'hA5);
        chk("a5_frame_err", fe_cnt - fe0, 32'd0);
        chk("a5_valid_pulses", vr_cnt - vr0, 32'd1);
        chk("a5_valid_cleared", {31'd0, rx_valid}, 32'd0);

        // ---------------- false start ----------------
        base = got.size();
        ticks(1'b0, 4);
        ticks(1'b1, 4);
        chk("false_start_cnt7", {27'd0, busy, sample_cnt}, {27'd0, 1'b1, 4'd7});
        ticks(1'b1, 1);
        chk("false_start_idle", {27'd0, busy, sample_cnt}, 32'd0);
        ticks(1'b1, 4);
        chk("false_start_no_data", got.size() - base, 32'd0);

        // ---------------- framing error ----------------
        base = got.size(); fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, NONE);
        chk("ferr_cycles", fe_cnt - fe0, 32'd1);
        chk("ferr_no_data", got.size() - base, 32'd0);
        chk("ferr_valid", {31'd0, rx_valid}, 32'd0);

        // ---------------- overrun ----------------
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, NONE);
        chk("ovr_first", {22'd0, rx_valid, overrun, rx_data}, {22'd0, 1'b1, 1'b0, 8'h3C});
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, NONE);
        chk("ovr_dropped", {22'd0, rx_valid, overrun, rx_data}, {22'd0, 1'b1, 1'b1, 8'h3C});
        rx_ready = 1'b1;
        @(posedge clk); #1;
        chk("ovr_accept", {30'd0, rx_valid, overrun}, 32'd0);

        // ---------------- accept on the same edge a frame lands ----------------
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, NONE);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, NONE);
        chk("same_edge_setup", {22'd0, rx_valid, overrun, rx_data}, {22'd0, 1'b1, 1'b1, 8'h11});
        base = got.size();
        send_frame(8'h22, 1'b1, 1'b0, 1'b1, NONE);
        chk("same_edge_load", {22'd0, rx_valid, overrun, rx_data}, {22'd0, 1'b1, 1'b1, 8'h22});
        chk("same_edge_old_taken", {24'd0, got[base]}, 32'h11);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        chk("same_edge_drain", {22'd0, rx_valid, overrun, rx_data}, {22'd0, 1'b0, 1'b0, 8'h22});

`ifdef UART_RX_PARITY_EN
        // ---------------- parity ----------------
        base = got.size(); pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, NONE);
        chk("par_bad_pulse", pe_cnt - pe0, 32'd1);
        chk("par_bad_no_data", got.size() - base, 32'd0);
        chk("par_bad_no_ferr", fe_cnt - fe0, 32'd0);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, NONE);
        chk("par_good_data", {24'd0, got[base]}, 32'h01);
        chk("par_good_no_err", pe_cnt - pe0, 32'd1);
`endif

        // ---------------- reset in the middle of a frame ----------------
        rx_ready = 1'b0;
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, NONE);
        send_frame(8'h69, 1'b1, 1'b0, 1'b0, NONE);
        chk("pre_rst_state", {22'd0, rx_valid, overrun, rx_data}, {22'd0, 1'b1, 1'b1, 8'h96});
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 4 * OS + 2);
        chk("pre_rst_bitcnt", {27'd0, busy, bit_cnt}, {27'd0, 1'b1, 4'd3});
        rst = 1'b1;
        #1;
        chk("mid_frame_reset", {rx_data, rx_valid, frame_err, parity_err, overrun, busy,
                                sample_cnt, bit_cnt}, 32'd0);
        rx_in = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rx_ready = 1'b1;
        base = got.size();
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, NONE);
        chk("after_rst_data", {24'd0, rx_data}, 32'h5A);
        chk("after_rst_got", {24'd0, got[base]}, 32'h5A);

        // ---------------- randomized frames vs. reference model ----------------
        rx_ready = 1'b1;
        base = got.size(); fe0 = fe_cnt; pe0 = pe_cnt;
        fe_exp = 0; pe_exp = 0;
        for (int unsigned k = 0; k < 24; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                ticks(1'b0, $urandom_range(1, 8));
                ticks(1'b1, 12);
                chk("rand_false_start_idle", {31'd0, busy}, 32'd0);
            end else begin
                logic [7:0] d;
                logic       sb;
                bit         fp;
                d  = 8'($urandom);
                sb = ($urandom_range(0, 4) != 0);
                fp = PAR_EN && ($urandom_range(0, 3) == 0);
                if (frame_good(sb, fp)) exp_q.push_back(d);
                if (!sb) fe_exp++;
                if (fp) pe_exp++;
                send_frame(d, sb, fp, 1'b0, NONE);
                ticks(1'b1, $urandom_range(0, 5));
            end
        end
        chk("rand_count", got.size() - base, exp_q.size());
        for (int unsigned i = 0; i < exp_q.size(); i++) begin
            chk("rand_data", {24'd0, got[base + i]}, {24'd0, exp_q[i]});
        end
        chk("rand_frame_err", fe_cnt - fe0, fe_exp);
        chk("rand_parity_err", pe_cnt - pe0, pe_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
